// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter
//   Shares the single vga_adapter plot port among NREQ drawing engines.
//   Each frame, engines that request the port are granted it one at a time
//   in round-robin order. A grant lasts until the engine pulses done or the
//   grant times out. Each engine is served at most once per frame.
//
// Ports
//   clk          system clock
//   resetn       asynchronous active-low reset
//   req          per-requester request
//   done         per-requester end-of-draw pulse (honoured only from the grantee)
//   x_in/y_in/colour_in/plot_in  packed per-requester pixel streams
//   gnt          one-hot grant, all-zero when no engine owns the port
//   x_out/y_out/colour_out/plot  pixel stream of the grantee, zero when idle
//   frame_tick   one-cycle pulse on the last cycle of each frame
//   busy         arbiter is arbitrating or a grant is active
//   timeout_err  sticky: a grant was force-revoked
//   overrun      sticky: a frame boundary arrived while busy
module vga_draw_arbiter #(
    parameter int NREQ          = 4,
    parameter int FRAME_CYCLES  = 833333,
    parameter int GRANT_TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   done,
    input  logic [8*NREQ-1:0] x_in,
    input  logic [7*NREQ-1:0] y_in,
    input  logic [3*NREQ-1:0] colour_in,
    input  logic [NREQ-1:0]   plot_in,
    output logic [NREQ-1:0]   gnt,
    output logic [7:0]        x_out,
    output logic [6:0]        y_out,
    output logic [2:0]        colour_out,
    output logic              plot,
    output logic              frame_tick,
    output logic              busy,
    output logic              timeout_err,
    output logic              overrun
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(FRAME_CYCLES);
    localparam int TW = $clog2(GRANT_TIMEOUT + 1);

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        ARB        = 2'd1,
        GRANT      = 2'd2
    } state_t;

    state_t            state_reg;
    logic [CW-1:0]     frame_cnt_reg;
    logic [TW-1:0]     tmo_cnt_reg;
    logic [NREQ-1:0]   gnt_reg;
    logic [NREQ-1:0]   served_reg;
    logic [IW-1:0]     last_reg;
    logic [IW-1:0]     gidx_reg;
    logic              tick_pending_reg;
    logic              timeout_err_reg;
    logic              overrun_reg;

    logic [NREQ-1:0]   eligible;
    logic              sel_found;
    logic [IW-1:0]     sel_idx;
    logic [NREQ-1:0]   sel_onehot;
    logic              tick;

    assign tick     = (frame_cnt_reg == CW'(FRAME_CYCLES - 1));
    assign eligible = req & ~served_reg;

    // Round-robin search starting just after the most recent grantee.
    always_comb begin
        int cand;
        cand      = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last_reg) + k) % NREQ;
            if (!sel_found && eligible[cand]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(cand);
            end
        end
        sel_onehot = NREQ'(1) << sel_idx;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg        <= WAIT_FRAME;
            frame_cnt_reg    <= '0;
            tmo_cnt_reg      <= '0;
            gnt_reg          <= '0;
            served_reg       <= '0;
            last_reg         <= IW'(NREQ - 1);
            gidx_reg         <= '0;
            tick_pending_reg <= 1'b0;
            timeout_err_reg  <= 1'b0;
            overrun_reg      <= 1'b0;
        end else begin
            frame_cnt_reg <= tick ? '0 : frame_cnt_reg + CW'(1);

            if (tick && state_reg != WAIT_FRAME)
                overrun_reg <= 1'b1;

            case (state_reg)
                WAIT_FRAME: begin
                    if (tick) begin
                        served_reg <= '0;
                        state_reg  <= ARB;
                    end
                end
                ARB: begin
                    if (sel_found) begin
                        gnt_reg     <= sel_onehot;
                        gidx_reg    <= sel_idx;
                        last_reg    <= sel_idx;
                        tmo_cnt_reg <= '0;
                        state_reg   <= GRANT;
                        if (tick)
                            tick_pending_reg <= 1'b1;
                    end else if (tick_pending_reg || tick) begin
                        // A frame boundary already passed (or is passing now):
                        // open a new round immediately instead of waiting.
                        served_reg       <= '0;
                        tick_pending_reg <= 1'b0;
                    end else begin
                        state_reg <= WAIT_FRAME;
                    end
                end
                GRANT: begin
                    if (tick)
                        tick_pending_reg <= 1'b1;
                    if (done[gidx_reg]) begin
                        served_reg[gidx_reg] <= 1'b1;
                        gnt_reg              <= '0;
                        state_reg            <= ARB;
                    end else if (tmo_cnt_reg == TW'(GRANT_TIMEOUT - 1)) begin
                        served_reg[gidx_reg] <= 1'b1;
                        gnt_reg              <= '0;
                        timeout_err_reg      <= 1'b1;
                        state_reg            <= ARB;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
                    end
                end
                default: begin
                    gnt_reg   <= '0;
                    state_reg <= WAIT_FRAME;
                end
            endcase
        end
    end

    // Output mux: each requester's slice is masked by its grant bit and the
    // masked slices are OR-ed; gnt is one-hot so at most one survives.
    logic [7:0] x_m   [NREQ];
    logic [6:0] y_m   [NREQ];
    logic [2:0] col_m [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_mux
        assign x_m[gi]   = gnt_reg[gi] ? x_in[8*gi +: 8]      : 8'd0;
        assign y_m[gi]   = gnt_reg[gi] ? y_in[7*gi +: 7]      : 7'd0;
        assign col_m[gi] = gnt_reg[gi] ? colour_in[3*gi +: 3] : 3'd0;
    end

    always_comb begin
        x_out      = 8'd0;
        y_out      = 7'd0;
        colour_out = 3'd0;
        for (int i = 0; i < NREQ; i++) begin
            x_out      = x_out | x_m[i];
            y_out      = y_out | y_m[i];
            colour_out = colour_out | col_m[i];
        end
    end

    assign plot        = |(gnt_reg & plot_in);
    assign gnt         = gnt_reg;
    assign frame_tick  = tick;
    assign busy        = (state_reg != WAIT_FRAME);
    assign timeout_err = timeout_err_reg;
    assign overrun     = overrun_reg;

endmodule
